// File: rtl/dma_io_peripheral_if.sv
// -----------------------------------------------------------------------------
// dma_io_peripheral_if
//   DMA bus-side signal bundle between the DMA controller and the I/O
//   responder.
//
//   Signals:
//     Dreq       DMA request (responder -> controller)
//     nDack      DMA acknowledge, active low (controller -> responder)
//     nIOR/nIOW  bus I/O read/write strobes, active low, synchronous to clock
//     nEOP       end of process, active low
//     DataIn     bus write data (captured on nIOW)
//     DataOut    bus read data (driven on nIOR)
//     DataOutEn  tri-state enable for DataOut
//
//   Modports:
//     master  controller side
//     slave   responder side
// -----------------------------------------------------------------------------
interface dma_io_peripheral_if;
    logic       Dreq;
    logic       nDack;
    logic       nIOR;
    logic       nIOW;
    logic       nEOP;
    logic [7:0] DataIn;
    logic [7:0] DataOut;
    logic       DataOutEn;

    modport master (
        input  Dreq, DataOut, DataOutEn,
        output nDack, nIOR, nIOW, nEOP, DataIn
    );

    modport slave (
        input  nDack, nIOR, nIOW, nEOP, DataIn,
        output Dreq, DataOut, DataOutEn
    );
endinterface

// File: rtl/dma_io_peripheral.sv
// -----------------------------------------------------------------------------
// dma_io_peripheral
//   I/O-side responder for single-cycle DMA bus transfers. Holds a TX byte
//   FIFO (device -> bus, read by nIOR) and an RX byte FIFO (bus -> device,
//   written by nIOW). Raises Dreq when it has data to give (Mode 01) or room
//   to take (Mode 10), and ends a block transfer on nEOP.
//
//   Optional feature macro: DMA_IO_WATERMARK_EN
//     defined   : IDLE->REQ needs TX count >= WATERMARK / RX free >= WATERMARK
//     undefined : threshold is 1 in both directions
//
//   Ports:
//     Clock, nReset        clock, asynchronous active-low reset
//     bus (slave modport)  Dreq/nDack/nIOR/nIOW/nEOP/DataIn/DataOut/DataOutEn
//     Mode[1:0]            01 DMA write (nIOR), 10 DMA read (nIOW), else idle
//     Enable               request enable; low clears Tc and Error
//     PushValid/PushData/PushReady   device -> TX FIFO
//     PopValid/PopData/PopReady      RX FIFO -> device
//     Done                 one-cycle pulse when EOP is accepted
//     Tc, Error            sticky terminal-count / underrun-overrun flags
//     state_dbg[1:0]       current FSM state (0 IDLE, 1 REQ, 2 ACTIVE, 3 TERM)
//
//   Handshake rule for the device ports: a transfer happens in every cycle
//   where valid and ready are both high at the rising edge; ready depends only
//   on registered counts, never on valid, and valid never waits on ready.
// -----------------------------------------------------------------------------
module dma_io_peripheral #(
    parameter int DEPTH     = 8,
    parameter int WATERMARK = 4
) (
    input  logic               Clock,
    input  logic               nReset,
    dma_io_peripheral_if.slave bus,
    input  logic [1:0]         Mode,
    input  logic               Enable,
    input  logic               PushValid,
    input  logic [7:0]         PushData,
    output logic               PushReady,
    output logic               PopValid,
    output logic [7:0]         PopData,
    input  logic               PopReady,
    output logic               Done,
    output logic               Tc,
    output logic               Error,
    output logic [1:0]         state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef DMA_IO_WATERMARK_EN
    localparam int THRESH = WATERMARK;
`else
    // WATERMARK has no effect in this build.
    localparam int THRESH = 1 + 0 * WATERMARK;
`endif

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_TERM   = 2'd3
    } state_t;

    // Registered state
    state_t        state_q, state_d;
    logic          dreq_q, dreq_d;
    logic          done_q, done_d;
    logic          tc_q, tc_d;
    logic          error_q, error_d;
    logic          ior_armed_q, ior_armed_d;
    logic          iow_armed_q, iow_armed_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];

    // Transfer events
    logic mode_wr, mode_rd;
    logic ior_accept, iow_accept;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic underrun, overrun;
    logic cond_now, cond_after;
    logic eop_accept;

    // ---------------------------------------------------------------- events
    always_comb begin
        mode_wr    = (Mode == 2'b01);
        mode_rd    = (Mode == 2'b10);
        // A strobe counts once per low pulse: only while armed.
        ior_accept = ~bus.nDack & ~bus.nIOR & ior_armed_q;
        iow_accept = ~bus.nDack & ~bus.nIOW & iow_armed_q;

        tx_push  = PushValid & PushReady;
        tx_pop   = ior_accept & mode_wr & (tx_cnt_q != '0);
        underrun = ior_accept & mode_wr & (tx_cnt_q == '0);
        rx_push  = iow_accept & mode_rd & (rx_cnt_q != DEPTH_C);
        overrun  = iow_accept & mode_rd & (rx_cnt_q == DEPTH_C);
        rx_pop   = PopValid & PopReady;

        eop_accept = (state_q == ST_ACTIVE) & ~bus.nEOP & ~bus.nDack;
    end

    // ----------------------------------------------------------- FIFO update
    always_comb begin
        tx_wr_d  = tx_wr_q + AW'(tx_push);
        tx_rd_d  = tx_rd_q + AW'(tx_pop);
        rx_wr_d  = rx_wr_q + AW'(rx_push);
        rx_rd_d  = rx_rd_q + AW'(rx_pop);

        tx_cnt_d = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase

        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase

        ior_armed_d = bus.nIOR ? 1'b1 : (ior_accept ? 1'b0 : ior_armed_q);
        iow_armed_d = bus.nIOW ? 1'b1 : (iow_accept ? 1'b0 : iow_armed_q);
    end

    // ------------------------------------------------------ request condition
    always_comb begin
        cond_now   = 1'b0;
        cond_after = 1'b0;
        if (mode_wr) begin
            cond_now   = (tx_cnt_q >= THRESH_C);
            // Once granted, keep requesting until TX runs dry.
            cond_after = (tx_cnt_d != '0);
        end else if (mode_rd) begin
            cond_now   = ((DEPTH_C - rx_cnt_q) >= THRESH_C);
            cond_after = (rx_cnt_d != DEPTH_C);
        end
    end

    // ------------------------------------------------------ FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Enable & ~tc_q & cond_now) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (~Enable | ~cond_now) state_d = ST_IDLE;
                else if (~bus.nDack)     state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (eop_accept)                    state_d = ST_TERM;
                else if (~cond_after & bus.nDack)  state_d = ST_IDLE;
            end
            ST_TERM: begin
                if (bus.nDack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------ FSM: outputs
    always_comb begin
        // Dreq is registered, so it follows the state being entered.
        dreq_d  = (state_d == ST_REQ) | ((state_d == ST_ACTIVE) & cond_after);
        done_d  = eop_accept;
        tc_d    = Enable & (tc_q | eop_accept);
        error_d = Enable & (error_q | underrun | overrun);
    end

    // ------------------------------------------------------ FSM: registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            dreq_q      <= 1'b0;
            done_q      <= 1'b0;
            tc_q        <= 1'b0;
            error_q     <= 1'b0;
            ior_armed_q <= 1'b1;
            iow_armed_q <= 1'b1;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            dreq_q      <= dreq_d;
            done_q      <= done_d;
            tc_q        <= tc_d;
            error_q     <= error_d;
            ior_armed_q <= ior_armed_d;
            iow_armed_q <= iow_armed_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
        end
    end

    // Storage needs no reset: counts gate every read.
    always_ff @(posedge Clock) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= PushData;
        if (rx_push) rx_mem_q[rx_wr_q] <= bus.DataIn;
    end

    // ------------------------------------------------------ outputs
    always_comb begin
        // Gated by reset so the bus is released while reset is held.
        bus.DataOutEn = nReset & ~bus.nDack & ~bus.nIOR & mode_wr;
        if (tx_cnt_q != '0) bus.DataOut = tx_mem_q[tx_rd_q];
        else                bus.DataOut = bus.DataOutEn ? 8'hFF : 8'h00;
        bus.Dreq  = dreq_q;
        PushReady = (tx_cnt_q != DEPTH_C);
        PopValid  = (rx_cnt_q != '0);
        PopData   = PopValid ? rx_mem_q[rx_rd_q] : 8'h00;
        Done      = done_q;
        Tc        = tc_q;
        Error     = error_q;
        state_dbg = state_q;
    end
endmodule
